// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - MIPS program-counter stage with stall-safe redirect capture
// Optional exception entry guarded by macro PC_EXC_EN (adds exc_req, epc and EXC_VECTOR).
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
`ifdef PC_EXC_EN
    ,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
`endif
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_pc4,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] jr_target,
`ifdef PC_EXC_EN
    input  logic        exc_req,
    output logic [31:0] epc,
`endif
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        flush,
    output logic        align_err
);

    typedef enum logic {
        RUN     = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pending_target;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] branch_offset;
    logic        jr_misaligned;

    assign pc_plus4      = pc + 32'd4;
    assign redirect      = jump_reg | jump | branch_taken;
    assign branch_offset = {{14{branch_imm[15]}}, branch_imm, 2'b00};
    assign jr_misaligned = jump_reg & (jr_target[1:0] != 2'b00);

    // Priority: register jump, then absolute jump, then conditional branch.
    always_comb begin
        target = branch_pc4 + branch_offset;
        if (jump_reg) begin
            target = {jr_target[31:2], 2'b00};
        end else if (jump) begin
            target = {branch_pc4[31:28], jump_index, 2'b00};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc             <= RESET_PC;
            state          <= RUN;
            pending_target <= '0;
            flush          <= 1'b0;
            fetch_valid    <= 1'b0;
            align_err      <= 1'b0;
`ifdef PC_EXC_EN
            epc            <= '0;
`endif
        end else begin
            fetch_valid <= ~stall;
`ifdef PC_EXC_EN
            // Exceptions override stall and any captured redirect.
            if (exc_req) begin
                pc             <= EXC_VECTOR;
                epc            <= pc;
                flush          <= 1'b1;
                pending_target <= '0;
                state          <= RUN;
            end else
`endif
            begin
                case (state)
                    RUN: begin
                        if (jr_misaligned) begin
                            align_err <= 1'b1;
                        end
                        if (!stall) begin
                            flush <= redirect;
                            pc    <= redirect ? target : pc_plus4;
                        end else begin
                            flush <= 1'b0;
                            if (redirect) begin
                                pending_target <= target;
                                state          <= PENDING;
                            end
                        end
                    end
                    PENDING: begin
                        // The stalled instruction cannot issue another redirect.
                        if (stall) begin
                            flush <= 1'b0;
                        end else begin
                            pc    <= pending_target;
                            flush <= 1'b1;
                            state <= RUN;
                        end
                    end
                    default: begin
                        flush <= 1'b0;
                        state <= RUN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit
module tb_pc_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_pc4;
    logic [15:0] branch_imm;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        flush;
    logic        align_err;
`ifdef PC_EXC_EN
    logic        exc_req;
    logic [31:0] epc;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic        flush;
        logic        fv;
        logic        ae;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    pc_fetch_unit dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_pc4   (branch_pc4),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_index   (jump_index),
        .jump_reg     (jump_reg),
        .jr_target    (jr_target),
`ifdef PC_EXC_EN
        .exc_req      (exc_req),
        .epc          (epc),
`endif
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .fetch_valid  (fetch_valid),
        .flush        (flush),
        .align_err    (align_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_now(input exp_t e);
        check("pc", pc, e.pc);
        check("pc_plus4", pc_plus4, e.pc + 32'd4);
        check("flush", {31'd0, flush}, {31'd0, e.flush});
        check("fetch_valid", {31'd0, fetch_valid}, {31'd0, e.fv});
        check("align_err", {31'd0, align_err}, {31'd0, e.ae});
    endtask

    // Monitor: one expectation per clock edge, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_now(e);
            end
        end
    end

    task automatic idle_inputs();
        stall        = 1'b0;
        branch_taken = 1'b0;
        branch_pc4   = 32'h0;
        branch_imm   = 16'h0;
        jump         = 1'b0;
        jump_index   = 26'h0;
        jump_reg     = 1'b0;
        jr_target    = 32'h0;
    endtask

    // One cycle of stimulus plus the state expected after the following edge.
    task automatic cyc(input logic st, input logic bt, input logic [31:0] pc4,
                       input logic [15:0] imm, input logic j, input logic [25:0] idx,
                       input logic jr, input logic [31:0] jrt,
                       input logic [31:0] e_pc, input logic e_fl, input logic e_fv,
                       input logic e_ae);
        exp_t e;
        @(negedge clock);
        reset_n      = 1'b1;
        stall        = st;
        branch_taken = bt;
        branch_pc4   = pc4;
        branch_imm   = imm;
        jump         = j;
        jump_index   = idx;
        jump_reg     = jr;
        jr_target    = jrt;
        e.pc = e_pc; e.flush = e_fl; e.fv = e_fv; e.ae = e_ae;
        exp_q.push_back(e);
    endtask

    task automatic none(input logic [31:0] e_pc, input logic e_ae);
        cyc(0, 0, 32'h0, 16'h0, 0, 26'h0, 0, 32'h0, e_pc, 0, 1, e_ae);
    endtask

    initial begin
        exp_t r;
        int   budget;
        reset_n = 1'b0;
        idle_inputs();
`ifdef PC_EXC_EN
        exc_req = 1'b0;
`endif
        r.pc = 32'h0; r.flush = 1'b0; r.fv = 1'b0; r.ae = 1'b0;
        #2;
        check_now(r);

        // Sequential run out of reset
        none(32'h4, 0);
        none(32'h8, 0);
        none(32'hC, 0);
        none(32'h10, 0);
        // Jump to 0x40, then backward branch to 0x3C
        cyc(0, 0, 32'h14, 16'h0, 1, 26'h10, 0, 32'h0, 32'h40, 1, 1, 0);
        cyc(0, 1, 32'h44, 16'hFFFE, 0, 26'h0, 0, 32'h0, 32'h3C, 1, 1, 0);
        none(32'h40, 0);
        // All three redirects at once: jump_reg wins
        cyc(0, 1, 32'h44, 16'h5, 1, 26'h20, 1, 32'h1000, 32'h1000, 1, 1, 0);
        none(32'h1004, 0);
        cyc(0, 1, 32'h44, 16'h5, 1, 26'h20, 1, 32'h1002, 32'h1000, 1, 1, 1);
        none(32'h1004, 1);
        // Jump captured during a 3-cycle stall; later redirects ignored
        cyc(1, 0, 32'h8000_0010, 16'h0, 1, 26'h100, 0, 32'h0, 32'h1004, 0, 0, 1);
        cyc(1, 1, 32'h100, 16'h4, 0, 26'h0, 0, 32'h0, 32'h1004, 0, 0, 1);
        cyc(1, 0, 32'h0, 16'h0, 0, 26'h0, 1, 32'h2000, 32'h1004, 0, 0, 1);
        none(32'h8000_0400, 1);
        exp_q[$].flush = 1'b1;
        none(32'h8000_0404, 1);
        // Plain stall holds pc
        cyc(1, 0, 32'h0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h8000_0404, 0, 0, 1);
        none(32'h8000_0408, 1);
        // Wrap-around
        cyc(0, 0, 32'h0, 16'h0, 0, 26'h0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 1, 1);
        none(32'h0, 1);
        // Reset while PENDING drops the captured redirect
        cyc(1, 0, 32'h0, 16'h0, 1, 26'h50, 0, 32'h0, 32'h0, 0, 0, 1);
        @(negedge clock);
        reset_n = 1'b0;
        idle_inputs();
        #1;
        check_now(r);
        exp_q.push_back(r);
        none(32'h4, 0);
        none(32'h8, 0);
`ifdef PC_EXC_EN
        cyc(0, 0, 32'h0, 16'h0, 1, 26'h80, 0, 32'h0, 32'h200, 1, 1, 0);
        cyc(1, 0, 32'h0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h180, 1, 0, 0);
        exc_req = 1'b1;
        @(negedge clock);
        exc_req = 1'b0;
        idle_inputs();
        check("epc", epc, 32'h200);
`endif

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(negedge clock);
            budget++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d expected=0 pending expectations", exp_q.size());
        end
        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
